if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_if.sv | 39 +++
 rtl/if_stage_if_id_reg.sv | 42 ++++
 rtl/if_stage.sv | 140 ++++++++++++++
 tb/tb_if_stage.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and fetch-state encoding for the IF stage.
// HALT exists only when IF_MISALIGN_TRAP_EN is defined.
package if_stage_pkg;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} fetch_state_t;
`else
  typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} fetch_state_t;
`endif

  function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// Control, ROM and IF/ID bundle of the fetch stage; master = if_stage side.
// id_misalign_o exists only when IF_MISALIGN_TRAP_EN is defined.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                   stall_if_i;
  logic                   stall_id_i;
  logic                   branch_flag_i;
  logic [InstAddrBus-1:0] branch_target_i;
  logic                   flush_i;
  logic [InstAddrBus-1:0] new_pc_i;
  logic [InstBus-1:0]     rom_inst_i;
  logic                   rom_ce_o;
  logic [InstAddrBus-1:0] rom_addr_o;
  logic [InstAddrBus-1:0] id_pc_o;
  logic [InstBus-1:0]     id_inst_o;
  logic                   id_valid_o;
`ifdef IF_MISALIGN_TRAP_EN
  logic                   id_misalign_o;
`endif

  modport master (
    input  stall_if_i, stall_id_i, branch_flag_i, branch_target_i,
    input  flush_i, new_pc_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
`ifdef IF_MISALIGN_TRAP_EN
    , output id_misalign_o
`endif
  );

  modport slave (
    output stall_if_i, stall_id_i, branch_flag_i, branch_target_i,
    output flush_i, new_pc_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
`ifdef IF_MISALIGN_TRAP_EN
    , input id_misalign_o
`endif
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold beats load; idle cycles bubble.
// One-edge latency; hold freezes the register while decode is stalled.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] pc_d,
  input  logic [31:0] inst_d,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);
  import if_stage_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= ZeroWord;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (bubble) begin
      id_pc    <= ZeroWord;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (hold) begin
      id_pc    <= id_pc;
      id_inst  <= id_inst;
      id_valid <= id_valid;
    end else if (load) begin
      id_pc    <= pc_d;
      id_inst  <= inst_d;
      id_valid <= 1'b1;
    end else begin
      id_pc    <= ZeroWord;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, pending redirect under stall, BOOT/RUN FSM, IF/ID register.
// Option IF_MISALIGN_TRAP_EN: misaligned redirect reports to decode and halts until flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic      clk,
  input logic      rst,
  if_stage_if.master bus
);
  import if_stage_pkg::*;

  fetch_state_t           state;
  logic                   ce;
  logic [InstAddrBus-1:0] pc;
  logic                   pend_valid;
  logic [InstAddrBus-1:0] pend_pc;

  logic                   run;
  logic                   br_now;
  logic                   pend_take;
  logic                   redirect;
  logic                   misalign;
  logic [InstAddrBus-1:0] redir_raw;
  logic [InstAddrBus-1:0] redir_tgt;

  assign run       = (state == RUN);
  assign br_now    = bus.branch_flag_i && !bus.stall_if_i;
  // A fresh unstalled branch supersedes whatever was pending.
  assign pend_take = pend_valid && !bus.stall_if_i && !bus.branch_flag_i;
  assign redirect  = run && !bus.flush_i && (br_now || pend_take);
  assign redir_raw = bus.branch_flag_i ? bus.branch_target_i : pend_pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign  = redirect && (redir_raw[1:0] != 2'b00);
  assign redir_tgt = redir_raw;
  assign bus.id_misalign_o = misalign_q;
`else
  assign misalign  = 1'b0;
  assign redir_tgt = align_word(redir_raw);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      ce         <= ChipDisable;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= ZeroWord;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          ce    <= ChipEnable;
        end
        RUN: begin
          if (bus.flush_i) begin
            pc         <= bus.new_pc_i;
            pend_valid <= 1'b0;
          end else if (br_now || pend_take) begin
            pend_valid <= 1'b0;
            if (misalign) begin
`ifdef IF_MISALIGN_TRAP_EN
              state <= HALT;
`endif
              ce    <= ChipDisable;
            end else begin
              pc <= redir_tgt;
            end
          end else if (bus.branch_flag_i) begin
            pend_valid <= 1'b1;
            pend_pc    <= bus.branch_target_i;
          end else if (!bus.stall_if_i) begin
            pc <= pc + 32'd4;
          end
        end
`ifdef IF_MISALIGN_TRAP_EN
        HALT: begin
          if (bus.flush_i) begin
            state      <= RUN;
            ce         <= ChipEnable;
            pc         <= bus.new_pc_i;
            pend_valid <= 1'b0;
          end
        end
`endif
        default: begin
          state <= BOOT;
          ce    <= ChipDisable;
        end
      endcase
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign;
  end
`endif

  logic                   ifid_bubble;
  logic                   ifid_hold;
  logic                   ifid_load;
  logic [InstAddrBus-1:0] ifid_pc;
  logic [InstBus-1:0]     ifid_inst;

  always_comb begin
    ifid_bubble = bus.flush_i || (bus.branch_flag_i && !bus.stall_id_i);
    ifid_hold   = bus.stall_id_i;
    // The word fetched while a pending redirect is consumed is wrong-path.
    ifid_load   = ce && !bus.stall_if_i && !pend_take;
    ifid_pc     = pc;
    ifid_inst   = bus.rom_inst_i;
    if (misalign) begin
      ifid_bubble = 1'b0;
      ifid_hold   = 1'b0;
      ifid_load   = 1'b1;
      ifid_pc     = redir_raw;
      ifid_inst   = NOP_INST;
    end
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble   (ifid_bubble),
    .hold     (ifid_hold),
    .load     (ifid_load),
    .pc_d     (ifid_pc),
    .inst_d   (ifid_inst),
    .id_pc    (bus.id_pc_o),
    .id_inst  (bus.id_inst_o),
    .id_valid (bus.id_valid_o)
  );

  assign bus.rom_addr_o = pc;
  assign bus.rom_ce_o   = ce;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: ROM word at byte address a is a/4+1.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_stage_if bus();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_inst_i = {2'b00, bus.rom_addr_o[31:2]} + 32'd1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        valid;
    logic        ce;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".addr"},  bus.rom_addr_o, e.addr);
    check({tag, ".ce"},    32'(bus.rom_ce_o), 32'(e.ce));
    check({tag, ".pc"},    bus.id_pc_o, e.id_pc);
    check({tag, ".inst"},  bus.id_inst_o, e.id_inst);
    check({tag, ".valid"}, 32'(bus.id_valid_o), 32'(e.valid));
`ifdef IF_MISALIGN_TRAP_EN
    check({tag, ".mis"},   32'(bus.id_misalign_o), 32'(e.mis));
`endif
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, compare after the edge.
  task automatic cyc(input string tag,
                     input logic sif, input logic sid, input logic br, input logic [31:0] bt,
                     input logic fl, input logic [31:0] np,
                     input logic [31:0] addr, input logic [31:0] id_pc, input logic [31:0] id_inst,
                     input logic valid, input logic ce, input logic mis);
    exp_t e;
    bus.stall_if_i      = sif;
    bus.stall_id_i      = sid;
    bus.branch_flag_i   = br;
    bus.branch_target_i = bt;
    bus.flush_i         = fl;
    bus.new_pc_i        = np;
    e.addr = addr; e.id_pc = id_pc; e.id_inst = id_inst;
    e.valid = valid; e.ce = ce; e.mis = mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      compare(tag, e);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    r.addr = 32'h0; r.id_pc = 32'h0; r.id_inst = NOP; r.valid = 1'b0; r.ce = 1'b0; r.mis = 1'b0;

    bus.stall_if_i = 0; bus.stall_id_i = 0; bus.branch_flag_i = 0;
    bus.branch_target_i = 0; bus.flush_i = 0; bus.new_pc_i = 0;
    #12;
    compare("rst", r);
    @(negedge clk);
    rst = 1'b0;

    //   tag      sif sid br  bt            fl  np            addr          id_pc         id_inst       v  ce mis
    cyc("boot",   0,  0,  0,  32'h0,        0,  32'h0,        32'h0,        32'h0,        NOP,          0, 1, 0);
    cyc("f0",     0,  0,  0,  32'h0,        0,  32'h0,        32'h4,        32'h0,        32'd1,        1, 1, 0);
    cyc("f4",     0,  0,  0,  32'h0,        0,  32'h0,        32'h8,        32'h4,        32'd2,        1, 1, 0);
    cyc("stl1",   1,  0,  0,  32'h0,        0,  32'h0,        32'h8,        32'h0,        NOP,          0, 1, 0);
    cyc("stl2",   1,  0,  0,  32'h0,        0,  32'h0,        32'h8,        32'h0,        NOP,          0, 1, 0);
    cyc("res8",   0,  0,  0,  32'h0,        0,  32'h0,        32'hC,        32'h8,        32'd3,        1, 1, 0);
    cyc("fC",     0,  0,  0,  32'h0,        0,  32'h0,        32'h10,       32'hC,        32'd4,        1, 1, 0);
    cyc("br40",   0,  0,  1,  32'h40,       0,  32'h0,        32'h40,       32'h0,        NOP,          0, 1, 0);
    cyc("t40",    0,  0,  0,  32'h0,        0,  32'h0,        32'h44,       32'h40,       32'd17,       1, 1, 0);
    cyc("pbr",    1,  0,  1,  32'h80,       0,  32'h0,        32'h44,       32'h0,        NOP,          0, 1, 0);
    cyc("pstl1",  1,  0,  0,  32'h0,        0,  32'h0,        32'h44,       32'h0,        NOP,          0, 1, 0);
    cyc("pstl2",  1,  0,  0,  32'h0,        0,  32'h0,        32'h44,       32'h0,        NOP,          0, 1, 0);
    cyc("ptake",  0,  0,  0,  32'h0,        0,  32'h0,        32'h80,       32'h0,        NOP,          0, 1, 0);
    cyc("t80",    0,  0,  0,  32'h0,        0,  32'h0,        32'h84,       32'h80,       32'd33,       1, 1, 0);
    cyc("pbr2",   1,  0,  1,  32'h80,       0,  32'h0,        32'h84,       32'h0,        NOP,          0, 1, 0);
    cyc("flush",  1,  1,  0,  32'h0,        1,  32'h100,      32'h100,      32'h0,        NOP,          0, 1, 0);
    cyc("t100",   0,  0,  0,  32'h0,        0,  32'h0,        32'h104,      32'h100,      32'd65,       1, 1, 0);
    cyc("t104",   0,  0,  0,  32'h0,        0,  32'h0,        32'h108,      32'h104,      32'd66,       1, 1, 0);
    cyc("hold",   1,  1,  0,  32'h0,        0,  32'h0,        32'h108,      32'h104,      32'd66,       1, 1, 0);
    cyc("t108",   0,  0,  0,  32'h0,        0,  32'h0,        32'h10C,      32'h108,      32'd67,       1, 1, 0);
`ifdef IF_MISALIGN_TRAP_EN
    cyc("mis",    0,  0,  1,  32'h42,       0,  32'h0,        32'h10C,      32'h42,       NOP,          1, 0, 1);
    cyc("halt",   0,  0,  0,  32'h0,        0,  32'h0,        32'h10C,      32'h0,        NOP,          0, 0, 0);
    cyc("hflush", 0,  0,  0,  32'h0,        1,  32'h200,      32'h200,      32'h0,        NOP,          0, 1, 0);
    cyc("t200",   0,  0,  0,  32'h0,        0,  32'h0,        32'h204,      32'h200,      32'd129,      1, 1, 0);
`else
    cyc("mask",   0,  0,  1,  32'h42,       0,  32'h0,        32'h40,       32'h0,        NOP,          0, 1, 0);
    cyc("tmask",  0,  0,  0,  32'h0,        0,  32'h0,        32'h44,       32'h40,       32'd17,       1, 1, 0);
`endif
    cyc("wflush", 0,  0,  0,  32'h0,        1,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       NOP,          0, 1, 0);
    cyc("wrap",   0,  0,  0,  32'h0,        0,  32'h0,        32'h0,        32'hFFFF_FFFC, 32'h4000_0000, 1, 1, 0);
    cyc("t0",     0,  0,  0,  32'h0,        0,  32'h0,        32'h4,        32'h0,        32'd1,        1, 1, 0);
    cyc("f24",    0,  0,  0,  32'h0,        1,  32'h24,       32'h24,       32'h0,        NOP,          0, 1, 0);
    cyc("t24",    0,  0,  0,  32'h0,        0,  32'h0,        32'h28,       32'h24,       32'd10,       1, 1, 0);

    #2;
    rst = 1'b1;
    #1;
    compare("arst", r);
    @(negedge clk);
    rst = 1'b0;
    cyc("reboot", 0,  0,  0,  32'h0,        0,  32'h0,        32'h0,        32'h0,        NOP,          0, 1, 0);
    cyc("rf0",    0,  0,  0,  32'h0,        0,  32'h0,        32'h4,        32'h0,        32'd1,        1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
